uart_tx: RTL and testbench

- UART transmitter: accepts parallel words over a valid/ready handshake and serialises each one on rs232_tx.
- Frame is LSB first: 1 start bit (0), DATAWIDTH data bits, 1 stop bit (1).
- A one-entry holding register lets the next word be accepted mid-frame, so back-to-back frames have no idle gap.
- Counterpart to the receive path, sharing the same bit timing; sits between the system-side producer and the RS-232 pin.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_baud_gen.sv | 18 +
 rtl/uart_tx.sv | 114 +++++++++++
 tb/tb_uart_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encodings, baud defaults and frame-length helper for the UART transmit and receive paths.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int BAUD_END_9600_50M = 5207;
  localparam int BAUD_END_SIM = 56;
  function automatic int frame_clocks(input int data_bits, input int baud_end, input bit parity);
    return (data_bits + 2 + int'(parity)) * (baud_end + 1);
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: enable-gated counter 0..BAUD_END emitting a bit_end pulse in the final count of each bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_CNT_WIDTH = 13,
  parameter int BAUD_END = BAUD_END_9600_50M
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic en,
  output logic bit_end
);
  logic [BAUD_CNT_WIDTH-1:0] baud_cnt;
  assign bit_end = en && baud_cnt == BAUD_CNT_WIDTH'(BAUD_END);
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) baud_cnt <= '0;
    else baud_cnt <= (en && !bit_end) ? baud_cnt + 1'b1 : '0;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready UART transmitter (start, LSB-first data, stop) with a one-word holding register.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int BAUD_CNT_WIDTH = 13,
  parameter int BIT_CNT_WIDTH = 4,
  parameter int BAUD_END = BAUD_END_9600_50M,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [DATAWIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 rs232_tx
);
  uart_state_t state, state_nxt;
  logic [DATAWIDTH-1:0] hold, shift, shift_nxt;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt, bit_cnt_nxt;
  logic hold_full, load, bit_end, tx_nxt, last_bit;
  uart_baud_gen #(.BAUD_CNT_WIDTH(BAUD_CNT_WIDTH), .BAUD_END(BAUD_END)) u_baud (
    .CLK(CLK),
    .RSTn(RSTn),
    .en(state != IDLE),
    .bit_end(bit_end)
  );
  assign tx_ready = ~hold_full;
  assign tx_done = state == STOP && bit_end;
  assign last_bit = bit_cnt == BIT_CNT_WIDTH'(DATAWIDTH - 1);
`ifdef UART_TX_PARITY_EN
  logic par;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) par <= 1'b0;
    else if (load) par <= ^hold ^ PARITY_ODD;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif
  // The line value is computed one cycle ahead so rs232_tx comes straight from a flop.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    bit_cnt_nxt = bit_cnt;
    tx_nxt = rs232_tx;
    load = 1'b0;
    case (state)
      IDLE: if (hold_full) begin
        load = 1'b1;
        state_nxt = START;
        tx_nxt = 1'b0;
      end
      START: if (bit_end) begin
        state_nxt = DATA;
        tx_nxt = shift[0];
      end
      DATA: if (bit_end) begin
        if (last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
          tx_nxt = par;
`else
          state_nxt = STOP;
          tx_nxt = 1'b1;
`endif
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          shift_nxt = shift >> 1;
          tx_nxt = shift[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_nxt = STOP;
        tx_nxt = 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        load = hold_full;
        state_nxt = hold_full ? START : IDLE;
        tx_nxt = ~hold_full;
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      shift_nxt = hold;
      bit_cnt_nxt = '0;
    end
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      rs232_tx <= 1'b1;
      tx_busy <= 1'b0;
      hold <= '0;
      hold_full <= 1'b0;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      rs232_tx <= tx_nxt;
      tx_busy <= state_nxt != IDLE;
      if (load) hold_full <= 1'b0;
      else if (tx_valid && tx_ready) begin
        hold <= tx_data;
        hold_full <= 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench; accepted words are queued and a line monitor checks each serial frame bit by bit.
module tb_uart_tx;
  localparam int DW = 8;
  localparam int BE = 56;
  localparam int BP = BE + 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam bit PODD = 1'b0;
  localparam int NB = DW + 2 + PB;
  localparam logic [9:0] A5_LINE = 10'b1101001010;

  logic CLK = 1'b0, RSTn = 1'b0, tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic tx_ready, tx_busy, tx_done, rs232_tx;
  int checks = 0, errors = 0, cyc = 0, frames = 0;
  logic [DW-1:0] sb[$];
  int start_q[$], done_q[$];

  uart_tx #(.DATAWIDTH(DW), .BAUD_CNT_WIDTH(13), .BIT_CNT_WIDTH(4), .BAUD_END(BE), .PARITY_ODD(PODD)) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .rs232_tx(rs232_tx)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (RSTn && tx_done === 1'b1) done_q.push_back(cyc);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a low line while idle starts a frame; every cycle of it is compared with the queued word.
  initial begin
    logic [15:0] eb;
    logic [DW-1:0] w;
    int bad_line, bad_done, bad_busy;
    bit aborted;
    forever begin
      @(negedge CLK);
      if (RSTn && rs232_tx === 1'b0) begin
        start_q.push_back(cyc);
        check("start_expected", sb.size(), 1);
        if (sb.size() != 0) begin
          w = sb.pop_front();
          eb = '1;
          eb[0] = 1'b0;
          for (int k = 0; k < DW; k++) eb[k+1] = w[k];
          if (PB == 1) eb[DW+1] = ^w ^ PODD;
          bad_line = 0; bad_done = 0; bad_busy = 0; aborted = 0;
          for (int i = 0; i < NB * BP; i++) begin
            if (i > 0) @(negedge CLK);
            if (!RSTn) begin
              aborted = 1;
              break;
            end
            if (rs232_tx !== eb[i/BP]) bad_line++;
            if (tx_done !== (i == NB * BP - 1)) bad_done++;
            if (tx_busy !== 1'b1) bad_busy++;
          end
          if (!aborted) begin
            check($sformatf("line_bits_%02h", w), bad_line, 0);
            check($sformatf("done_timing_%02h", w), bad_done, 0);
            check($sformatf("busy_in_frame_%02h", w), bad_busy, 0);
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] w, output int acc);
    int t;
    @(posedge CLK);
    #1 tx_data = w;
    tx_valid = 1'b1;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (tx_ready !== 1'b1 && t < 3000);
    check($sformatf("accept_ready_%02h", w), tx_ready, 1);
    acc = cyc;
    if (tx_ready === 1'b1) begin
      sb.push_back(w);
      frames++;
    end
    @(posedge CLK);
    #1 tx_valid = 1'b0;
    tx_data = ~w;
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_q.size() < n && t < 5000) begin
      @(posedge CLK);
      t++;
    end
    check($sformatf("done_reached_%0d", n), done_q.size() >= n, 1);
  endtask

  task automatic wait_start(input int n);
    int t = 0;
    while (start_q.size() <= n && t < 3000) begin
      @(posedge CLK);
      t++;
    end
    check($sformatf("start_seen_%0d", n), start_q.size() > n, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a0, a1, a2, s, d, bad;
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_line", rs232_tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_ready", tx_ready, 1);
    #2 RSTn = 1'b1;
    repeat (5) @(negedge CLK);

    s = start_q.size();
    send(8'hA5, a);
    wait_start(s);
    repeat (27) @(negedge CLK);
    for (int b = 0; b < 9; b++) begin
      check($sformatf("a5_mid_bit_%0d", b), rs232_tx, A5_LINE[b]);
      repeat (BP) @(negedge CLK);
    end
    wait_done(1);
    @(negedge CLK);
    check("a5_busy_fall", tx_busy, 0);
    check("a5_start_latency", start_q[s] - a, 2);
    check("a5_done_latency", done_q[0] - start_q[s], NB * BP - 1);

    s = start_q.size();
    d = done_q.size();
    send(8'h00, a0);
    send(8'hFF, a1);
    send(8'h5A, a2);
    check("bp_accept_after_stop", a2 - done_q[d], 1);
    wait_done(d + 3);
    @(negedge CLK);
    check("b2b_busy_fall", tx_busy, 0);
    check("b2b_no_gap", start_q[s+1] - done_q[d], 1);
    check("b2b_done_spacing", done_q[d+1] - done_q[d], NB * BP);
    check("b2b_start_spacing", start_q[s+1] - start_q[s], NB * BP);

    s = start_q.size();
    d = done_q.size();
    send(8'h81, a);
    frames--;
    wait_start(s);
    repeat (4 * BP + 20) @(negedge CLK);
    #2 RSTn = 1'b0;
    #1;
    check("midrst_line", rs232_tx, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_ready", tx_ready, 1);
    repeat (5) @(negedge CLK);
    check("midrst_no_done", done_q.size(), d);
    sb.delete();
    #2 RSTn = 1'b1;
    repeat (3) @(negedge CLK);
    send(8'h3C, a);
    wait_done(d + 1);

`ifdef UART_TX_PARITY_EN
    s = start_q.size();
    d = done_q.size();
    send(8'h07, a);
    wait_start(s);
    repeat (9 * BP + 27) @(negedge CLK);
    check("par07_bit", rs232_tx, PODD ? 1'b0 : 1'b1);
    wait_done(d + 1);
    check("par07_frame_len", done_q[d] - start_q[s] + 1, 627);
`endif

    d = done_q.size();
    s = start_q.size();
    bad = 0;
    repeat (10000) begin
      @(negedge CLK);
      if (rs232_tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);
    check("idle_no_done", done_q.size(), d);
    check("idle_no_start", start_q.size(), s);
    check("sb_empty", sb.size(), 0);
    check("total_done", done_q.size(), frames);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
